// File: rtl/rotating_priority_selector.sv
// Picks the first set candidate bit, scanning upward from a start index and wrapping
// at SIZE. SIZE need not be a power of two.
module rotating_priority_selector #(
  parameter int unsigned SIZE = 4
) (
  input  logic [SIZE-1:0]         candidates,
  input  logic [$clog2(SIZE)-1:0] start,
  output logic [SIZE-1:0]         select,
  output logic [$clog2(SIZE)-1:0] index,
  output logic                    found
);

  localparam int unsigned INDEX_WIDTH = $clog2(SIZE);

  int unsigned position;

  always_comb begin
    select   = '0;
    index    = '0;
    found    = 1'b0;
    position = 0;
    for (int unsigned offset = 0; offset < SIZE; offset++) begin
      position = 32'(start) + offset;
      // Wrap by subtraction so non-power-of-two sizes need no modulo.
      if (position >= SIZE) begin
        position = position - SIZE;
      end
      if (!found && candidates[position]) begin
        found            = 1'b1;
        select[position] = 1'b1;
        index            = INDEX_WIDTH'(position);
      end
    end
  end

endmodule

// File: rtl/round_robin_distributor.sv
// Fans one valid/ready stream out to SIZE one-entry channel registers, filling the
// next empty slot at or after a rotating pointer.
module round_robin_distributor #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      upstream_data,
  input  logic                  upstream_valid,
  output logic                  upstream_ready,
  output logic [SIZE*WIDTH-1:0] downstream_data,
  output logic [SIZE-1:0]       downstream_valid,
  input  logic [SIZE-1:0]       downstream_ready
);

  localparam int unsigned INDEX_WIDTH = $clog2(SIZE);

  logic [SIZE-1:0]            slot_valid_q, slot_valid_d;
  logic [SIZE-1:0][WIDTH-1:0] slot_data_q, slot_data_d;
  logic [INDEX_WIDTH-1:0]     pointer_q, pointer_d;
  logic [SIZE-1:0]            select;
  logic [INDEX_WIDTH-1:0]     target;
  logic                       found;
  logic                       accept;

  rotating_priority_selector #(
    .SIZE(SIZE)
  ) u_selector (
    .candidates(~slot_valid_q),
    .start     (pointer_q),
    .select    (select),
    .index     (target),
    .found     (found)
  );

  // Only registered occupancy counts: a slot draining this cycle is not yet free.
  assign upstream_ready   = !reset && found;
  assign accept           = upstream_valid && upstream_ready;
  assign downstream_valid = slot_valid_q;
  assign downstream_data  = slot_data_q;

  always_comb begin
    slot_valid_d = slot_valid_q & ~downstream_ready;
    slot_data_d  = slot_data_q;
    pointer_d    = pointer_q;
    if (accept) begin
      slot_valid_d = slot_valid_d | select;
      for (int unsigned i = 0; i < SIZE; i++) begin
        if (select[i]) begin
          slot_data_d[i] = upstream_data;
        end
      end
      pointer_d = (target == INDEX_WIDTH'(SIZE - 1)) ? '0 : target + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid_q <= '0;
      slot_data_q  <= '0;
      pointer_q    <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      pointer_q    <= pointer_d;
    end
  end

endmodule
